// File: rtl/gen_share_arbiter_pkg.sv
// Shared definitions for the gen_share_arbiter slice: FSM state encodings
// and the arbitration policy selectors used by the MODE parameter.
package gen_arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/gen_share_arbiter_pick.sv
// Combinational rotating priority picker: first set bit of elig at or after
// base (wrapping modulo N) wins. base = 0 degenerates to lowest-index-wins.
module arb_prio_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] base,
  output logic [N-1:0]    win_oh,
  output logic [ID_W-1:0] win_id,
  output logic            any
);

  always_comb begin
    win_oh = '0;
    win_id = '0;
    any    = 1'b0;
    // First pass covers base..N-1, second pass the wrapped part 0..base-1.
    for (int j = 0; j < N; j++) begin
      if (!any && elig[j] && (j >= int'(base))) begin
        any       = 1'b1;
        win_oh[j] = 1'b1;
        win_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && elig[j]) begin
        any       = 1'b1;
        win_oh[j] = 1'b1;
        win_id    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/gen_share_arbiter.sv
// Arbiter sharing one downstream resource among N requesters, with grant
// hold, optional forced release after MAX_HOLD cycles and a one-cycle gap.
module gen_share_arbiter
  import gen_arb_defs::*;
#(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            timeout
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_e        state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      tmo_mask_q, tmo_mask_d;

  logic [N-1:0]    elig_masked;
  logic [N-1:0]    elig;
  logic [ID_W-1:0] pick_base;
  logic [N-1:0]    pick_oh;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic            owner_req;

  // A timed-out requester that is the only one asking wins again.
  assign elig_masked = req & ~tmo_mask_q;
  assign elig        = (|elig_masked) ? elig_masked : req;
  assign owner_req   = |(req & gnt_q);

  generate
    if (MODE == ARB_RR) begin : g_rr
      assign pick_base = ptr_q;
    end else begin : g_fixed
      assign pick_base = '0;
    end
  endgenerate

  arb_prio_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .elig   (elig),
    .base   (pick_base),
    .win_oh (pick_oh),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    tmo_mask_d  = tmo_mask_q;
    case (state_q)
      ARB_IDLE: begin
        if (en && pick_any) begin
          state_d     = ARB_BUSY;
          gnt_d       = pick_oh;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          tmo_mask_d  = '0;
          ptr_d       = (pick_id == ID_W'(N - 1)) ? '0 : pick_id + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        if (!owner_req || (HOLD_EN && hold_cnt_q == HOLD_LAST)) begin
          state_d     = ARB_GAP;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          // Voluntary release takes precedence over a coincident timeout.
          if (owner_req) begin
            timeout_d  = 1'b1;
            tmo_mask_d = gnt_q;
          end
        end
      end
      ARB_GAP: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
      tmo_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
      tmo_mask_q  <= tmo_mask_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_gen_share_arbiter.sv
// Bench for gen_share_arbiter: three configurations (fixed, round-robin,
// fixed with MAX_HOLD=3) checked every cycle against a behavioural model.
module tb_gen_share_arbiter;

  localparam int NDUT = 3;
  localparam int MODE_T [NDUT] = '{0, 1, 0};
  localparam int MH_T   [NDUT] = '{0, 0, 3};

  typedef struct {
    int owner;   // -1 when nothing is granted
    bit gap;
    int held;    // granted cycles completed so far
    int masked;  // -1 when no requester is excluded
    int ptr;
    bit tmo;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_v [NDUT];
  logic       en_v  [NDUT];
  logic [3:0] req_v [NDUT];
  logic [3:0] gnt_v [NDUT];
  logic       val_v [NDUT];
  logic [1:0] id_v  [NDUT];
  logic       tmo_v [NDUT];

  model_t m [NDUT];
  bit     chk_on = 1'b0;
  int     checks = 0;
  int     errors = 0;

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] wr_exp [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

  always #5 clk = ~clk;

  gen_share_arbiter #(.N(4), .ID_W(2), .MODE(0), .MAX_HOLD(0), .HOLD_W(8)) dut_fp (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .req(req_v[0]),
    .gnt(gnt_v[0]), .gnt_valid(val_v[0]), .gnt_id(id_v[0]), .timeout(tmo_v[0])
  );

  gen_share_arbiter #(.N(4), .ID_W(2), .MODE(1), .MAX_HOLD(0), .HOLD_W(8)) dut_rr (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .req(req_v[1]),
    .gnt(gnt_v[1]), .gnt_valid(val_v[1]), .gnt_id(id_v[1]), .timeout(tmo_v[1])
  );

  gen_share_arbiter #(.N(4), .ID_W(2), .MODE(0), .MAX_HOLD(3), .HOLD_W(8)) dut_to (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .req(req_v[2]),
    .gnt(gnt_v[2]), .gnt_valid(val_v[2]), .gnt_id(id_v[2]), .timeout(tmo_v[2])
  );

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1; r.gap = 1'b0; r.held = 0; r.masked = -1; r.ptr = 0; r.tmo = 1'b0;
    return r;
  endfunction

  // One clock of the arbitration rules, written in terms of owner index and
  // elapsed grant cycles.
  function automatic model_t step(model_t s, bit rst, bit en, logic [3:0] req,
                                  int mode, int mh);
    model_t n = s;
    logic [3:0] elig;
    int win;
    n.tmo = 1'b0;
    if (rst) return model_reset();
    if (s.gap) begin
      n.gap = 1'b0;
    end else if (s.owner >= 0) begin
      if (!req[s.owner]) begin
        n.owner = -1; n.gap = 1'b1;
      end else if (mh != 0 && s.held + 1 == mh) begin
        n.masked = s.owner; n.owner = -1; n.gap = 1'b1; n.tmo = 1'b1;
      end else begin
        n.held = s.held + 1;
      end
    end else if (en && req != 4'b0) begin
      elig = req;
      if (s.masked >= 0) elig[s.masked] = 1'b0;
      if (elig == 4'b0) elig = req;
      win = -1;
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (mode == 1) ? (s.ptr + i) % 4 : i;
        if (win < 0 && elig[idx]) win = idx;
      end
      n.owner = win; n.held = 0; n.masked = -1; n.ptr = (win + 1) % 4;
    end
    return n;
  endfunction

  task automatic chk(string name, int d, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %b want %b", name, d, $time, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial for (int d = 0; d < NDUT; d++) m[d] = model_reset();

  always @(posedge clk)
    for (int d = 0; d < NDUT; d++)
      m[d] <= step(m[d], rst_v[d], en_v[d], req_v[d], MODE_T[d], MH_T[d]);

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < NDUT; d++) begin
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m[d].owner >= 0) ? 4'(1 << m[d].owner) : 4'b0;
        ei = (m[d].owner >= 0) ? 2'(m[d].owner) : 2'd0;
        chk("model_gnt", d, gnt_v[d], eg);
        chk("model_gnt_id", d, {2'b0, id_v[d]}, {2'b0, ei});
        chk("model_gnt_valid", d, {3'b0, val_v[d]}, {3'b0, m[d].owner >= 0});
        chk("model_timeout", d, {3'b0, tmo_v[d]}, {3'b0, m[d].tmo});
      end
    end
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_v[d] = 1'b1; en_v[d] = 1'b0; req_v[d] = 4'b0;
    end
    tick(2);
    for (int d = 0; d < NDUT; d++) rst_v[d] = 1'b0;
    chk_on = 1'b1;
    for (int d = 0; d < NDUT; d++) chk("reset_gnt", d, gnt_v[d], 4'b0);

    // Fixed priority: 1010 -> index 1, then index 3 after one gap cycle.
    en_v[0] = 1'b1; req_v[0] = 4'b1010;
    tick(1);
    chk("fp_gnt", 0, gnt_v[0], 4'b0010);
    chk("fp_id", 0, {2'b0, id_v[0]}, 4'd1);
    tick(2);
    chk("fp_hold", 0, gnt_v[0], 4'b0010);
    req_v[0] = 4'b1000;
    tick(1); chk("fp_release", 0, gnt_v[0], 4'b0);
    tick(1); chk("fp_gap", 0, gnt_v[0], 4'b0);
    tick(1); chk("fp_next", 0, gnt_v[0], 4'b1000);
    chk("fp_next_id", 0, {2'b0, id_v[0]}, 4'd3);
    req_v[0] = 4'b0;
    tick(3);

    // Enable gating.
    en_v[0] = 1'b0; req_v[0] = 4'b0100;
    tick(3); chk("en_block", 0, gnt_v[0], 4'b0);
    en_v[0] = 1'b1;
    tick(1); chk("en_grant", 0, gnt_v[0], 4'b0100);
    en_v[0] = 1'b0;
    tick(3); chk("en_persist", 0, gnt_v[0], 4'b0100);
    req_v[0] = 4'b0;
    tick(1); chk("en_release", 0, gnt_v[0], 4'b0);
    tick(2);

    // Round-robin with 1-cycle grants and all requesters active.
    en_v[1] = 1'b1; req_v[1] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1); chk("rr_order", 1, gnt_v[1], rr_exp[k]);
      req_v[1] = 4'b1111 & ~rr_exp[k];
      tick(1); chk("rr_gap1", 1, gnt_v[1], 4'b0);
      req_v[1] = 4'b1111;
      tick(1); chk("rr_gap2", 1, gnt_v[1], 4'b0);
    end

    // Reset mid-grant: pointer must return to 0.
    req_v[1] = 4'b0100;
    tick(1); chk("rst_pre", 1, gnt_v[1], 4'b0100);
    rst_v[1] = 1'b1; req_v[1] = 4'b1111;
    tick(1);
    chk("rst_gnt", 1, gnt_v[1], 4'b0);
    chk("rst_valid", 1, {3'b0, val_v[1]}, 4'b0);
    chk("rst_id", 1, {2'b0, id_v[1]}, 4'b0);
    rst_v[1] = 1'b0;
    tick(1); chk("rst_next_winner", 1, gnt_v[1], 4'b0001);
    req_v[1] = 4'b0;
    tick(2);
    rst_v[1] = 1'b1;
    tick(1);
    rst_v[1] = 1'b0;

    // Pointer wrap with only requesters 0 and 3.
    req_v[1] = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick(1); chk("wrap_order", 1, gnt_v[1], wr_exp[k]);
      req_v[1] = 4'b1001 & ~wr_exp[k];
      tick(1);
      req_v[1] = 4'b1001;
      tick(1);
    end
    req_v[1] = 4'b0;
    tick(2);

    // Timeout after 3 cycles, then the other requester wins.
    en_v[2] = 1'b1; req_v[2] = 4'b0011;
    tick(1); chk("to_c1", 2, gnt_v[2], 4'b0001);
    tick(1); chk("to_c2", 2, gnt_v[2], 4'b0001);
    tick(1); chk("to_c3", 2, gnt_v[2], 4'b0001);
    tick(1); chk("to_drop", 2, gnt_v[2], 4'b0);
    chk("to_pulse", 2, {3'b0, tmo_v[2]}, 4'b0001);
    tick(1); chk("to_pulse_end", 2, {3'b0, tmo_v[2]}, 4'b0);
    tick(1); chk("to_other", 2, gnt_v[2], 4'b0010);
    req_v[2] = 4'b0;
    tick(3);

    // Lone requester is re-granted despite its own timeout.
    req_v[2] = 4'b0001;
    tick(3); chk("lone_c3", 2, gnt_v[2], 4'b0001);
    tick(1); chk("lone_pulse", 2, {3'b0, tmo_v[2]}, 4'b0001);
    tick(1); chk("lone_gap", 2, gnt_v[2], 4'b0);
    tick(1); chk("lone_regrant", 2, gnt_v[2], 4'b0001);
    req_v[2] = 4'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
